// File: rtl/alu_pipe_param.sv
// alu_pipe_param
// Two-stage pipelined ALU with a valid/ready handshake on both sides and
// full backpressure. S1 captures {a, b, op}. S2 holds the computed
// {c, flags, err} until the consumer takes it. An internal accumulator
// serves the ACC/CLR opcodes.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   operand beat valid          in_ready   beat accepted this cycle
//   a, b, op   operands / shift amount / opcode
//   out_valid  result valid                out_ready  consumer takes result
//   c          result                      flags      {neg, zero, carry, ovf}
//   err        illegal opcode on this result
//
// Build option: define ALU_SAT_EN to saturate ADD/SUB/ACC to the signed
// range on overflow. The default build wraps modulo 2^WIDTH.
module alu_pipe_param #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SH = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(7);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(9);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(10);
    localparam logic [OPW-1:0] OP_ACC  = OPW'(11);
    localparam logic [OPW-1:0] OP_CLR  = OPW'(12);

    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [OPW-1:0]   op1_q, op1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_adv, s1_adv;
    logic [WIDTH-1:0] add_x, add_y, diff, res;
    logic [WIDTH:0]   sum_ext;
    logic             add_ovf, sub_ovf, carry, ovf, illegal;
    logic [SH-1:0]    shamt;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;

    // ACC shares the adder with ADD, using acc as the left operand. acc_q is
    // written on the same edge the ACC beat leaves S1, so the next beat
    // already sees the updated value and back-to-back ACCs chain.
    always_comb begin
        add_x   = (op1_q == OP_ACC) ? acc_q : a1_q;
        add_y   = (op1_q == OP_ACC) ? a1_q : b1_q;
        sum_ext = {1'b0, add_x} + {1'b0, add_y};
        add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != add_x[WIDTH-1]);
        diff    = a1_q - b1_q;
        sub_ovf = (a1_q[WIDTH-1] != b1_q[WIDTH-1]) &&
                  (diff[WIDTH-1] != a1_q[WIDTH-1]);
        shamt   = b1_q[SH-1:0];
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op1_q)
            OP_ADD, OP_ACC: begin
                res   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = add_ovf;
`ifdef ALU_SAT_EN
                if (add_ovf) res = add_x[WIDTH-1] ? SAT_LO : SAT_HI;
`endif
            end
            OP_SUB: begin
                res   = diff;
                carry = (a1_q < b1_q);
                ovf   = sub_ovf;
`ifdef ALU_SAT_EN
                if (sub_ovf) res = a1_q[WIDTH-1] ? SAT_LO : SAT_HI;
`endif
            end
            OP_AND:  res = a1_q & b1_q;
            OP_OR:   res = a1_q | b1_q;
            OP_XOR:  res = a1_q ^ b1_q;
            OP_NOR:  res = ~(a1_q | b1_q);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a1_q) < $signed(b1_q))};
            OP_SLL:  res = a1_q << shamt;
            OP_SRL:  res = a1_q >> shamt;
            OP_SRA:  res = $signed(a1_q) >>> shamt;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a1_q < b1_q)};
            OP_CLR:  res = '0;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a1_d       = a1_q;
        b1_d       = b1_q;
        op1_d      = op1_q;
        s2_valid_d = s2_valid_q;
        c_d        = c_q;
        flags_d    = flags_q;
        err_d      = err_q;
        acc_d      = acc_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a1_d  = a;
                b1_d  = b;
                op1_d = op;
            end
        end

        if (s2_adv) s2_valid_d = s1_valid_q;

        if (s1_adv) begin
            c_d     = res;
            err_d   = illegal;
            flags_d = illegal ? 4'b0000
                              : {res[WIDTH-1], (res == '0), carry, ovf};
            if (op1_q == OP_ACC) acc_d = res;
            if (op1_q == OP_CLR) acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            op1_q      <= '0;
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            op1_q      <= op1_d;
            s2_valid_q <= s2_valid_d;
            c_q        <= c_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign c         = c_q;
    assign flags     = flags_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_pipe_param.sv
// Bench for alu_pipe_param at WIDTH=8: directed beats, an integer-arithmetic
// model fed in acceptance order, and a compare process on every output beat.
module tb_alu_pipe_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0, b = '0;
    logic [3:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] c;
    logic [3:0] flags;
    logic       err;

    int checks = 0;
    int errors = 0;
    int emit_cnt = 0;

    typedef struct {
        logic [7:0] c;
        logic [3:0] f;
        logic       e;
    } res_t;

    res_t       exp_q[$];
    res_t       mres, got;
    int         model_acc = 0;
    bit         pin_en = 0;
    logic [7:0] pin_c = '0;
    logic [3:0] pin_f = '0;
    logic       pin_e = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_c;
    logic [3:0] prev_f;
    logic       prev_e;

    alu_pipe_param #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference behaviour from plain integer arithmetic.
    function automatic res_t model(input int o, input int x, input int y);
        res_t r;
        int   v, cy, ov, e, s, lhs, rhs, sh;
        v = 0; cy = 0; ov = 0; e = 0;
        sh = y % 8;
        case (o)
            0, 11: begin
                lhs = (o == 11) ? model_acc : x;
                rhs = (o == 11) ? x : y;
                s   = lhs + rhs;
                v   = s % 256;
                cy  = (s > 255) ? 1 : 0;
                s   = sx(lhs) + sx(rhs);
                ov  = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_SAT_EN
                if (ov != 0) v = (s > 127) ? 127 : 128;
`endif
                if (o == 11) model_acc = v;
            end
            1: begin
                v  = (x - y + 256) % 256;
                cy = (x < y) ? 1 : 0;
                s  = sx(x) - sx(y);
                ov = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_SAT_EN
                if (ov != 0) v = (s > 127) ? 127 : 128;
`endif
            end
            2:  v = x & y;
            3:  v = x | y;
            4:  v = x ^ y;
            5:  v = (~(x | y)) & 255;
            6:  v = (sx(x) < sx(y)) ? 1 : 0;
            7:  v = (x << sh) & 255;
            8:  v = x >> sh;
            9:  v = (sx(x) >>> sh) & 255;
            10: v = (x < y) ? 1 : 0;
            12: begin model_acc = 0; v = 0; end
            default: e = 1;
        endcase
        r.c = v[7:0];
        r.e = e[0];
        r.f = (e != 0) ? 4'b0000 : {v[7], (v == 0), cy[0], ov[0]};
        return r;
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_acc = 0;
            prev_stall = 1'b0;
            chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_c", {24'd0, c}, {24'd0, prev_c});
                chk("stall_flags", {28'd0, flags}, {28'd0, prev_f});
                chk("stall_err", {31'd0, err}, {31'd0, prev_e});
            end
            if (out_valid && out_ready) begin
                emit_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat: got c=%0h, required no beat", c);
                end else begin
                    got = exp_q.pop_front();
                    chk("out_c", {24'd0, c}, {24'd0, got.c});
                    chk("out_flags", {28'd0, flags}, {28'd0, got.f});
                    chk("out_err", {31'd0, err}, {31'd0, got.e});
                end
            end
            if (in_valid && in_ready) begin
                mres = model(int'(op), int'(a), int'(b));
                exp_q.push_back(mres);
                if (pin_en) begin
                    chk("pin_c", {24'd0, mres.c}, {24'd0, pin_c});
                    chk("pin_flags", {28'd0, mres.f}, {28'd0, pin_f});
                    chk("pin_err", {31'd0, mres.e}, {31'd0, pin_e});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c = c;
            prev_f = flags;
            prev_e = err;
        end
    end

    // Presents one beat and holds it until accepted (bounded).
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input bit pe, input logic [7:0] pc, input logic [3:0] pf,
                        input logic pee);
        op = o; a = x; b = y; in_valid = 1'b1;
        pin_en = pe; pin_c = pc; pin_f = pf; pin_e = pee;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                pin_en = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: op=%0d not accepted within 30 cycles", o);
        in_valid = 1'b0;
        pin_en = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    int base_emit;

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_c", {24'd0, c}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        send(4'd0,  8'hF0, 8'h20, 1, 8'h10, 4'b0010, 1'b0);
`ifdef ALU_SAT_EN
        send(4'd1,  8'h80, 8'h01, 1, 8'h80, 4'b1001, 1'b0);
`else
        send(4'd1,  8'h80, 8'h01, 1, 8'h7F, 4'b0001, 1'b0);
`endif
        send(4'd6,  8'hFF, 8'h01, 1, 8'h01, 4'b0000, 1'b0);
        send(4'd10, 8'hFF, 8'h01, 1, 8'h00, 4'b0100, 1'b0);
        send(4'd9,  8'h90, 8'h0A, 1, 8'hE4, 4'b1000, 1'b0);
        send(4'd8,  8'h90, 8'h0A, 1, 8'h24, 4'b0000, 1'b0);
        send(4'd14, 8'h12, 8'h34, 1, 8'h00, 4'b0000, 1'b1);
        send(4'd12, 8'h00, 8'h00, 1, 8'h00, 4'b0100, 1'b0);
        send(4'd11, 8'h05, 8'h00, 1, 8'h05, 4'b0000, 1'b0);
        send(4'd11, 8'h07, 8'h00, 1, 8'h0C, 4'b0000, 1'b0);
        send(4'd11, 8'hFC, 8'h00, 1, 8'h08, 4'b0010, 1'b0);
        send(4'd7,  8'h81, 8'h0B, 1, 8'h08, 4'b0000, 1'b0);
        send(4'd2,  8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 1'b0);
        send(4'd5,  8'hF0, 8'h0C, 1, 8'h03, 4'b0000, 1'b0);
        send(4'd3,  8'hA0, 8'h05, 0, 8'h00, 4'b0000, 1'b0);
        send(4'd4,  8'hFF, 8'h0F, 0, 8'h00, 4'b0000, 1'b0);
        send(4'd0,  8'h7F, 8'h01, 0, 8'h00, 4'b0000, 1'b0);
        send(4'd1,  8'h00, 8'h01, 1, 8'hFF, 4'b1010, 1'b0);
        send(4'd15, 8'h00, 8'h00, 1, 8'h00, 4'b0000, 1'b1);
        drain();

        // Backpressure: two beats fill the pipe, the third must wait.
        base_emit = emit_cnt;
        out_ready = 1'b0;
        send(4'd0, 8'h01, 8'h01, 1, 8'h02, 4'b0000, 1'b0);
        send(4'd0, 8'h02, 8'h02, 1, 8'h04, 4'b0000, 1'b0);
        op = 4'd0; a = 8'h03; b = 8'h03; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_c", {24'd0, c}, 32'h02);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(4'd0, 8'h03, 8'h03, 1, 8'h06, 4'b0000, 1'b0);
        send(4'd0, 8'h04, 8'h04, 1, 8'h08, 4'b0000, 1'b0);
        drain();
        chk("bp_emit_count", emit_cnt - base_emit, 32'd4);

        // Reset with beats in flight and acc = 0x33.
        base_emit = emit_cnt;
        send(4'd11, 8'h2B, 8'h00, 1, 8'h33, 4'b0000, 1'b0);
        drain();
        out_ready = 1'b0;
        send(4'd0, 8'h01, 8'h01, 0, 8'h00, 4'b0000, 1'b0);
        send(4'd0, 8'h02, 8'h02, 0, 8'h00, 4'b0000, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        send(4'd11, 8'h01, 8'h00, 1, 8'h01, 4'b0000, 1'b0);
        drain();
        chk("rst_emit_count", emit_cnt - base_emit, 32'd2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
